// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   fetch_state_e : fetch FSM encoding (IDLE / WAIT / DISCARD)
//   fifo_entry_t  : one queued fetch result {instruction, PC+4}
//   INSTR_W, ADDR_W, PC_STEP : datapath widths and sequential PC increment
package if_prefetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no outstanding request
    ST_WAIT    = 2'd1,  // one outstanding request, response is kept
    ST_DISCARD = 2'd2   // one outstanding request, response is dropped
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_4;
  } fifo_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// if_fifo: synchronous FIFO holding fetched {instr, pc_4} entries.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i/push_data_i : write one entry (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   flush_i       : empty the FIFO; wins over push and pop
//   count_o       : number of valid entries (0..DEPTH)
//   head_o        : head entry, no read latency; stale when empty
module if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction-fetch front end ahead of the IF/ID register.
// Issues at most one outstanding request to a variable-latency instruction
// memory, queues returned words with their PC+4, and hands them to ID with a
// valid/ready handshake. A redirect flushes the queue, retargets fetch_pc and
// turns an in-flight request into one whose response is discarded.
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o        : fetch request and word-aligned address
//   imem_gnt_i                     : request accepted when req && gnt
//   imem_rvalid_i, imem_rdata_i    : response strobe and instruction word
//   redirect_i, redirect_pc_i      : taken branch from MEM and its target
//   instr_valid_o, instr_o, pc_4_o : FIFO head towards ID
//   instr_ready_i                  : ID consumes the head
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_4_o,
  input  logic               instr_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic              fifo_push;
  logic              fifo_pop;
  fifo_entry_t       fifo_wdata;
  fifo_entry_t       fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    fifo_push  = 1'b0;
    fifo_wdata = '{instr: imem_rdata_i, pc_4: req_addr_q + PC_STEP};

    // Only one request in flight; a free slot is required at issue time so
    // the eventual push can never find the FIFO full.
    imem_req_o  = (state_q == ST_IDLE) && (fifo_count < CNT_W'(DEPTH)) &&
                  !redirect_i && !rst_i;
    imem_addr_o = fetch_pc_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      case (state_q)
        ST_WAIT, ST_DISCARD: state_d = imem_rvalid_i ? ST_IDLE : ST_DISCARD;
        default:             state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_req_o && imem_gnt_i) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            req_addr_d = fetch_pc_q;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            fifo_push = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (imem_rvalid_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign instr_valid_o = (fifo_count != '0);
  assign fifo_pop      = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = fifo_head.instr;
  assign pc_4_o        = fifo_head.pc_4;

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_i),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // A response with nothing outstanding breaks the memory protocol.
  a_no_rvalid_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(state_q == ST_IDLE && imem_rvalid_i));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed, table-driven bench for if_prefetch_unit with a small memory
// model returning addr ^ 32'hA5A5_0000 after a programmable latency.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_4_o;
  logic        instr_ready = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_cnt = 0;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_4_o        (pc_4_o),
    .instr_ready_i (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, memory model
  // updated, then outputs settle and are left for the caller to check.
  task automatic cyc(input logic r, input logic rdy, input logic g,
                     input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; instr_ready = rdy; gnt = g; redirect = rd; redirect_pc = rpc;
    if (r) begin
      pend = 1'b0; rvalid = 1'b0;
    end else if (pend && pend_cnt == 1) begin
      rvalid = 1'b1; rdata = mem_word(pend_addr); pend = 1'b0;
    end else begin
      rvalid = 1'b0;
      if (pend) pend_cnt--;
    end
    #1;
    if (imem_req_o && gnt) begin
      pend = 1'b1; pend_addr = imem_addr_o; pend_cnt = lat;
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
  endtask

  typedef struct {
    logic        rdy, g, rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Streaming fetch: gnt=1, 1-cycle latency, ID always ready.
    vecs[0] = '{1, 1, 0, 0, 1, 32'h0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 32'h0, 0, 0, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 32'h4, 1, 32'hA5A5_0000, 32'h4};
    vecs[3] = '{1, 1, 0, 0, 0, 32'h0, 0, 0, 0};
    vecs[4] = '{1, 1, 0, 0, 1, 32'h8, 1, 32'hA5A5_0004, 32'h8};
    vecs[5] = '{1, 1, 0, 0, 0, 32'h0, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 1, 32'hC, 1, 32'hA5A5_0008, 32'hC};

    lat = 1;
    do_reset();
    foreach (vecs[i]) begin
      cyc(0, vecs[i].rdy, vecs[i].g, vecs[i].rd, vecs[i].rpc);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_instr", i), instr_o, vecs[i].e_instr);
        chk($sformatf("v%0d_pc4", i), pc_4_o, vecs[i].e_pc4);
      end
    end

    // Back-pressure: exactly DEPTH words queue, then requests stop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, '0);
      if (i % 2 == 0) begin
        chk("fill_req", {31'b0, imem_req_o}, 32'd1);
        chk("fill_addr", imem_addr_o, 32'(i * 2));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, '0);
      chk("full_req", {31'b0, imem_req_o}, 32'd0);
      chk("full_pc4", pc_4_o, 32'h4);
    end
    cyc(0, 1, 1, 0, '0);
    chk("pop1_req", {31'b0, imem_req_o}, 32'd0);
    chk("pop1_pc4", pc_4_o, 32'h4);
    cyc(0, 0, 1, 0, '0);
    chk("after_pop_req", {31'b0, imem_req_o}, 32'd1);
    chk("after_pop_addr", imem_addr_o, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, '0);
      chk("drain_valid", {31'b0, instr_valid_o}, 32'd1);
      chk("drain_pc4", pc_4_o, 32'(8 + 4 * i));
      chk("drain_instr", instr_o, mem_word(32'(4 + 4 * i)));
    end

    // Grant withheld: request and address hold, fetch_pc moves only on grant.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, '0);
      chk("nogrant_req", {31'b0, imem_req_o}, 32'd1);
      chk("nogrant_addr", imem_addr_o, 32'h0);
    end
    cyc(0, 1, 1, 0, '0);
    chk("grant_addr", imem_addr_o, 32'h0);
    cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 1, 0, '0);
    chk("postgrant_addr", imem_addr_o, 32'h4);

    // Redirect while WAIT with 3-cycle latency; target bits [1:0] ignored.
    lat = 3;
    do_reset();
    cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 1, 1, 32'h0000_0106);
    chk("rdw_req", {31'b0, imem_req_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("rdw_valid1", {31'b0, instr_valid_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("rdw_stale_req", {31'b0, imem_req_o}, 32'd0);
    chk("rdw_valid2", {31'b0, instr_valid_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("rdw_new_req", {31'b0, imem_req_o}, 32'd1);
    chk("rdw_new_addr", imem_addr_o, 32'h104);
    chk("rdw_valid3", {31'b0, instr_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 1, 0, '0);
    chk("rdw_out_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("rdw_out_pc4", pc_4_o, 32'h108);
    chk("rdw_out_instr", instr_o, 32'hA5A5_0104);

    // Redirect coinciding with rvalid and a pop, two entries queued.
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, '0);
    cyc(0, 1, 1, 1, 32'h0000_0200);
    chk("rdc_pre_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("rdc_req", {31'b0, imem_req_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("rdc_flushed", {31'b0, instr_valid_o}, 32'd0);
    chk("rdc_req2", {31'b0, imem_req_o}, 32'd1);
    chk("rdc_addr2", imem_addr_o, 32'h200);
    cyc(0, 1, 1, 0, '0);
    chk("rdc_valid3", {31'b0, instr_valid_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("rdc_out_pc4", pc_4_o, 32'h204);
    chk("rdc_out_instr", instr_o, 32'hA5A5_0200);

    // Address wrap at 0xFFFF_FFFC, then reset asserted in DISCARD.
    do_reset();
    cyc(0, 1, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_redir_req", {31'b0, imem_req_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("wrap_req_addr", imem_addr_o, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, '0);
    lat = 3;
    cyc(0, 1, 1, 0, '0);
    chk("wrap_pc4", pc_4_o, 32'h0);
    chk("wrap_instr", instr_o, 32'h5A5A_FFFC);
    chk("wrap_next_addr", imem_addr_o, 32'h0);
    cyc(0, 1, 1, 1, 32'h0000_0040);
    cyc(1, 1, 1, 0, '0);
    chk("disc_rst_req", {31'b0, imem_req_o}, 32'd0);
    cyc(0, 1, 1, 0, '0);
    chk("disc_rel_req", {31'b0, imem_req_o}, 32'd1);
    chk("disc_rel_addr", imem_addr_o, 32'h0);
    chk("disc_rel_valid", {31'b0, instr_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
